// File: rtl/lsu_pkg.sv
// lsu_pkg: shared types and helpers for the load/store unit.
//   size_t      - access size encoding driven by the core (func3[1:0])
//   err_cause_t - completion cause code reported alongside core_err
//   lsu_state_t - LSU control state, also exposed for debug
//   lane_off_w  - number of address bits selecting a byte lane in a bus beat
package lsu_pkg;

    typedef enum logic [1:0] {
        BYTE  = 2'b00,
        HALF  = 2'b01,
        WORD  = 2'b10,
        DWORD = 2'b11
    } size_t;

    typedef enum logic [1:0] {
        ERR_NONE     = 2'd0,
        ERR_MISALIGN = 2'd1,
        ERR_BUS      = 2'd2,
        ERR_TIMEOUT  = 2'd3
    } err_cause_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } lsu_state_t;

    // 2 for a 32-bit bus, 3 for a 64-bit bus.
    function automatic int lane_off_w(input int data_w);
        return $clog2(data_w / 8);
    endfunction

endpackage

// File: rtl/lsu_align.sv
// lsu_align: combinational byte-lane steering for a DATA_W-wide data bus.
// Ports:
//   i_size      access size
//   i_off       byte offset of the access inside the bus beat
//   i_unsigned  1 = zero-extend loads, 0 = sign-extend
//   i_wdata     store data, LSB-justified
//   i_rdata     raw bus read beat
//   o_be        byte enables for the access
//   o_wdata     store data shifted onto its byte lanes
//   o_rdata     load data moved to the LSBs, truncated and extended
//   o_misalign  access is not naturally aligned or not supported by this width
module lsu_align
    import lsu_pkg::*;
#(
    parameter  int DATA_W = 32,
    localparam int NB     = DATA_W / 8,
    localparam int OFF_W  = lane_off_w(DATA_W)
) (
    input  size_t              i_size,
    input  logic [OFF_W-1:0]   i_off,
    input  logic               i_unsigned,
    input  logic [DATA_W-1:0]  i_wdata,
    input  logic [DATA_W-1:0]  i_rdata,
    output logic [NB-1:0]      o_be,
    output logic [DATA_W-1:0]  o_wdata,
    output logic [DATA_W-1:0]  o_rdata,
    output logic               o_misalign
);

    logic [NB-1:0]     w_be_base;
    logic [DATA_W-1:0] w_mask;
    logic [DATA_W-1:0] w_shifted;
    logic              w_sign;
    logic [OFF_W+2:0]  w_bit_off;

    assign w_bit_off = {i_off, 3'b000};

    always_comb begin
        w_be_base  = '0;
        w_mask     = '0;
        w_sign     = 1'b0;
        o_misalign = 1'b0;
        w_shifted  = i_rdata >> w_bit_off;
        case (i_size)
            BYTE: begin
                w_be_base = NB'(1);
                w_mask    = DATA_W'(8'hFF);
                w_sign    = w_shifted[7];
            end
            HALF: begin
                w_be_base  = NB'(2'b11);
                w_mask     = DATA_W'(16'hFFFF);
                w_sign     = w_shifted[15];
                o_misalign = i_off[0];
            end
            WORD: begin
                w_be_base  = NB'(4'hF);
                w_mask     = DATA_W'(32'hFFFF_FFFF);
                w_sign     = w_shifted[31];
                o_misalign = (i_off & OFF_W'(3)) != '0;
            end
            DWORD: begin
                w_be_base  = '1;
                w_mask     = '1;
                w_sign     = w_shifted[DATA_W-1];
                // A double cannot be carried by a 32-bit beat at all.
                o_misalign = (DATA_W != 64) || ((i_off & OFF_W'(7)) != '0);
            end
            default: ;
        endcase
        o_be    = w_be_base << i_off;
        o_wdata = i_wdata << w_bit_off;
        // Keep the selected bytes, fill everything above with the sign bit
        // (or zeros for unsigned loads).
        o_rdata = (w_shifted & w_mask) |
                  ({DATA_W{w_sign & ~i_unsigned}} & ~w_mask);
    end

endmodule

// File: rtl/lsu.sv
// lsu: load/store unit between the core's data-memory request and a
// ready/valid data bus with wait states.
// Ports:
//   clk, rst             clock, asynchronous active-low reset
//   core_valid/ready     request strobe / LSU idle
//   core_write           1 = store
//   core_unsigned        1 = zero-extend load
//   core_size            access size (size_t encoding)
//   core_addr/wdata      byte address / LSB-justified store data
//   core_done            one-cycle completion pulse
//   core_rdata           extended load data (held until next completion)
//   core_err/err_cause   error flag and cause (held until next completion)
//   bus_*                registered bus request, bus_ready/bus_err/bus_rdata response
//   dbg_state            current control state
//
// Handshakes: the core request is taken on any rising edge where
// core_ready & core_valid; core_valid is ignored otherwise. The bus request
// is presented with bus_valid=1 and all bus_* outputs are held stable until
// the edge where bus_valid & bus_ready, which completes the transfer and
// samples bus_rdata and bus_err.
module lsu
    import lsu_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                core_valid,
    output logic                core_ready,
    input  logic                core_write,
    input  logic                core_unsigned,
    input  logic [1:0]          core_size,
    input  logic [ADDR_W-1:0]   core_addr,
    input  logic [DATA_W-1:0]   core_wdata,
    output logic                core_done,
    output logic [DATA_W-1:0]   core_rdata,
    output logic                core_err,
    output logic [1:0]          core_err_cause,
    output logic                bus_valid,
    input  logic                bus_ready,
    output logic                bus_write,
    output logic [ADDR_W-1:0]   bus_addr,
    output logic [DATA_W/8-1:0] bus_be,
    output logic [DATA_W-1:0]   bus_wdata,
    input  logic [DATA_W-1:0]   bus_rdata,
    input  logic                bus_err,
    output logic [1:0]          dbg_state
);

    localparam int NB    = DATA_W / 8;
    localparam int OFF_W = lane_off_w(DATA_W);
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    lsu_state_t        r_state;
    lsu_state_t        w_next;

    size_t             r_size;
    logic [OFF_W-1:0]  r_off;
    logic              r_unsigned;
    logic              r_write;
    logic [CNT_W-1:0]  r_cnt;

    logic              r_bus_valid;
    logic              r_bus_write;
    logic [ADDR_W-1:0] r_bus_addr;
    logic [NB-1:0]     r_bus_be;
    logic [DATA_W-1:0] r_bus_wdata;

    logic [DATA_W-1:0] r_rdata;
    logic              r_err;
    err_cause_t        r_cause;

    size_t             w_size;
    logic [OFF_W-1:0]  w_off;
    logic              w_unsigned;
    logic [NB-1:0]     w_be;
    logic [DATA_W-1:0] w_wdata_lane;
    logic [DATA_W-1:0] w_rdata_ext;
    logic              w_misalign;
    logic              w_timeout;

    // The aligner sees the live request while idle (lane/alignment decode)
    // and the latched request while on the bus (load extraction).
    assign w_size     = (r_state == IDLE) ? size_t'(core_size) : r_size;
    assign w_off      = (r_state == IDLE) ? core_addr[OFF_W-1:0] : r_off;
    assign w_unsigned = (r_state == IDLE) ? core_unsigned : r_unsigned;

    lsu_align #(
        .DATA_W (DATA_W)
    ) u_align (
        .i_size     (w_size),
        .i_off      (w_off),
        .i_unsigned (w_unsigned),
        .i_wdata    (core_wdata),
        .i_rdata    (bus_rdata),
        .o_be       (w_be),
        .o_wdata    (w_wdata_lane),
        .o_rdata    (w_rdata_ext),
        .o_misalign (w_misalign)
    );

    // r_cnt counts BUS cycles that ended without bus_ready.
    assign w_timeout = (TIMEOUT != 0) && (r_cnt == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (core_valid) w_next = w_misalign ? RESP : BUS;
            BUS:     if (bus_ready || w_timeout) w_next = RESP;
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_size      <= BYTE;
            r_off       <= '0;
            r_unsigned  <= 1'b0;
            r_write     <= 1'b0;
            r_cnt       <= '0;
            r_bus_valid <= 1'b0;
            r_bus_write <= 1'b0;
            r_bus_addr  <= '0;
            r_bus_be    <= '0;
            r_bus_wdata <= '0;
            r_rdata     <= '0;
            r_err       <= 1'b0;
            r_cause     <= ERR_NONE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (core_valid) begin
                        r_size     <= size_t'(core_size);
                        r_off      <= core_addr[OFF_W-1:0];
                        r_unsigned <= core_unsigned;
                        r_write    <= core_write;
                        r_cnt      <= '0;
                        if (w_misalign) begin
                            r_rdata <= '0;
                            r_err   <= 1'b1;
                            r_cause <= ERR_MISALIGN;
                        end else begin
                            r_bus_valid <= 1'b1;
                            r_bus_write <= core_write;
                            r_bus_addr  <= {core_addr[ADDR_W-1:OFF_W], OFF_W'(0)};
                            r_bus_be    <= w_be;
                            r_bus_wdata <= w_wdata_lane;
                        end
                    end
                end
                BUS: begin
                    // Ready takes priority over an expiring timeout.
                    if (bus_ready || w_timeout) begin
                        r_bus_valid <= 1'b0;
                        r_bus_write <= 1'b0;
                        r_bus_addr  <= '0;
                        r_bus_be    <= '0;
                        r_bus_wdata <= '0;
                    end
                    if (bus_ready) begin
                        r_err   <= bus_err;
                        r_cause <= bus_err ? ERR_BUS : ERR_NONE;
                        r_rdata <= (bus_err || r_write) ? '0 : w_rdata_ext;
                    end else if (w_timeout) begin
                        r_err   <= 1'b1;
                        r_cause <= ERR_TIMEOUT;
                        r_rdata <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign core_ready     = (r_state == IDLE);
    assign core_done      = (r_state == RESP);
    assign core_rdata     = r_rdata;
    assign core_err       = r_err;
    assign core_err_cause = r_cause;
    assign bus_valid      = r_bus_valid;
    assign bus_write      = r_bus_write;
    assign bus_addr       = r_bus_addr;
    assign bus_be         = r_bus_be;
    assign bus_wdata      = r_bus_wdata;
    assign dbg_state      = r_state;

endmodule

// File: tb/tb_lsu.sv
module tb_lsu;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // shared request fields
    logic        c_write, c_uns;
    logic [1:0]  c_size;
    logic [31:0] c_addr;
    logic [31:0] c_wdata32;
    logic [63:0] c_wdata64;
    logic [31:0] rdata32;
    logic [63:0] rdata64;

    // u_a: 32-bit, default timeout
    logic        a_valid, a_ready, a_done, a_err;
    logic [1:0]  a_cause, a_dbg;
    logic [31:0] a_rdata, a_baddr, a_bwdata;
    logic        a_bvalid, a_bready, a_bwrite, a_berr;
    logic [3:0]  a_bbe;

    // u_t: 32-bit, TIMEOUT=4
    logic        t_valid, t_ready, t_done, t_err;
    logic [1:0]  t_cause, t_dbg;
    logic [31:0] t_rdata, t_baddr, t_bwdata;
    logic        t_bvalid, t_bready, t_bwrite, t_berr;
    logic [3:0]  t_bbe;

    // u_d: 64-bit
    logic        d_valid, d_ready, d_done, d_err;
    logic [1:0]  d_cause, d_dbg;
    logic [63:0] d_rdata, d_bwdata;
    logic [31:0] d_baddr;
    logic        d_bvalid, d_bready, d_bwrite, d_berr;
    logic [7:0]  d_bbe;

    lsu #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(255)) u_a (
        .clk(clk), .rst(rst),
        .core_valid(a_valid), .core_ready(a_ready), .core_write(c_write),
        .core_unsigned(c_uns), .core_size(c_size), .core_addr(c_addr),
        .core_wdata(c_wdata32), .core_done(a_done), .core_rdata(a_rdata),
        .core_err(a_err), .core_err_cause(a_cause),
        .bus_valid(a_bvalid), .bus_ready(a_bready), .bus_write(a_bwrite),
        .bus_addr(a_baddr), .bus_be(a_bbe), .bus_wdata(a_bwdata),
        .bus_rdata(rdata32), .bus_err(a_berr), .dbg_state(a_dbg)
    );

    lsu #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) u_t (
        .clk(clk), .rst(rst),
        .core_valid(t_valid), .core_ready(t_ready), .core_write(c_write),
        .core_unsigned(c_uns), .core_size(c_size), .core_addr(c_addr),
        .core_wdata(c_wdata32), .core_done(t_done), .core_rdata(t_rdata),
        .core_err(t_err), .core_err_cause(t_cause),
        .bus_valid(t_bvalid), .bus_ready(t_bready), .bus_write(t_bwrite),
        .bus_addr(t_baddr), .bus_be(t_bbe), .bus_wdata(t_bwdata),
        .bus_rdata(rdata32), .bus_err(t_berr), .dbg_state(t_dbg)
    );

    lsu #(.ADDR_W(32), .DATA_W(64), .TIMEOUT(255)) u_d (
        .clk(clk), .rst(rst),
        .core_valid(d_valid), .core_ready(d_ready), .core_write(c_write),
        .core_unsigned(c_uns), .core_size(c_size), .core_addr(c_addr),
        .core_wdata(c_wdata64), .core_done(d_done), .core_rdata(d_rdata),
        .core_err(d_err), .core_err_cause(d_cause),
        .bus_valid(d_bvalid), .bus_ready(d_bready), .bus_write(d_bwrite),
        .bus_addr(d_baddr), .bus_be(d_bbe), .bus_wdata(d_bwdata),
        .bus_rdata(rdata64), .bus_err(d_berr), .dbg_state(d_dbg)
    );

    // ---------------- scenarios ----------------
    task automatic test_reset();
        @(negedge clk);
        total++; if (a_ready !== 1'b1) begin bad++; $display("FAIL rst_ready got=%0h exp=1", a_ready); end
        total++; if (a_bvalid !== 1'b0) begin bad++; $display("FAIL rst_bus_valid got=%0h exp=0", a_bvalid); end
        total++; if (a_bbe !== 4'h0 || a_baddr !== 32'h0 || a_bwdata !== 32'h0 || a_bwrite !== 1'b0) begin
            bad++; $display("FAIL rst_bus_fields be=%0h addr=%0h wdata=%0h wr=%0h exp=0", a_bbe, a_baddr, a_bwdata, a_bwrite); end
        total++; if (a_done !== 1'b0 || a_err !== 1'b0 || a_cause !== 2'd0) begin
            bad++; $display("FAIL rst_core_status done=%0h err=%0h cause=%0h exp=0", a_done, a_err, a_cause); end
        total++; if (a_rdata !== 32'h0) begin bad++; $display("FAIL rst_rdata got=%0h exp=0", a_rdata); end
        total++; if (d_bvalid !== 1'b0 || d_ready !== 1'b1) begin
            bad++; $display("FAIL rst_d_state bvalid=%0h ready=%0h exp=0/1", d_bvalid, d_ready); end
        rst = 1'b1;
    endtask

    task automatic test_load_byte(input logic uns, input logic [31:0] exp);
        @(negedge clk);
        c_write = 1'b0; c_uns = uns; c_size = 2'b00; c_addr = 32'h1003;
        rdata32 = 32'h80FF_FF00; a_bready = 1'b1; a_berr = 1'b0; a_valid = 1'b1;
        @(negedge clk);
        a_valid = 1'b0;
        total++; if (a_bvalid !== 1'b1) begin bad++; $display("FAIL lb_bus_valid u=%0d got=%0h exp=1", uns, a_bvalid); end
        total++; if (a_baddr !== 32'h1000) begin bad++; $display("FAIL lb_bus_addr u=%0d got=%0h exp=1000", uns, a_baddr); end
        total++; if (a_bbe !== 4'b1000) begin bad++; $display("FAIL lb_bus_be u=%0d got=%0b exp=1000", uns, a_bbe); end
        total++; if (a_done !== 1'b0) begin bad++; $display("FAIL lb_early_done u=%0d got=%0h exp=0", uns, a_done); end
        @(negedge clk);
        total++; if (a_done !== 1'b1) begin bad++; $display("FAIL lb_done u=%0d got=%0h exp=1", uns, a_done); end
        total++; if (a_rdata !== exp) begin bad++; $display("FAIL lb_rdata u=%0d got=%0h exp=%0h", uns, a_rdata, exp); end
        total++; if (a_err !== 1'b0) begin bad++; $display("FAIL lb_err u=%0d got=%0h exp=0", uns, a_err); end
        total++; if (a_bvalid !== 1'b0) begin bad++; $display("FAIL lb_bus_drop u=%0d got=%0h exp=0", uns, a_bvalid); end
        @(negedge clk);
        a_bready = 1'b0;
        total++; if (a_done !== 1'b0 || a_ready !== 1'b1) begin
            bad++; $display("FAIL lb_pulse u=%0d done=%0h ready=%0h exp=0/1", uns, a_done, a_ready); end
        total++; if (a_rdata !== exp) begin bad++; $display("FAIL lb_rdata_hold u=%0d got=%0h exp=%0h", uns, a_rdata, exp); end
    endtask

    task automatic test_store_half();
        @(negedge clk);
        c_write = 1'b1; c_uns = 1'b0; c_size = 2'b01; c_addr = 32'h2002;
        c_wdata32 = 32'h0000_BEEF; a_bready = 1'b0; a_berr = 1'b0; a_valid = 1'b1;
        @(negedge clk);
        a_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            total++; if (a_bvalid !== 1'b1 || a_bwrite !== 1'b1) begin
                bad++; $display("FAIL sh_valid cyc=%0d valid=%0h write=%0h exp=1/1", i, a_bvalid, a_bwrite); end
            total++; if (a_baddr !== 32'h2000 || a_bbe !== 4'b1100) begin
                bad++; $display("FAIL sh_addr_be cyc=%0d addr=%0h be=%0b exp=2000/1100", i, a_baddr, a_bbe); end
            total++; if (a_bwdata !== 32'hBEEF_0000) begin
                bad++; $display("FAIL sh_wdata cyc=%0d got=%0h exp=beef0000", i, a_bwdata); end
            total++; if (a_done !== 1'b0) begin bad++; $display("FAIL sh_early_done cyc=%0d got=%0h exp=0", i, a_done); end
            if (i == 3) a_bready = 1'b1;
            @(negedge clk);
        end
        a_bready = 1'b0;
        total++; if (a_done !== 1'b1) begin bad++; $display("FAIL sh_done got=%0h exp=1", a_done); end
        total++; if (a_err !== 1'b0 || a_rdata !== 32'h0) begin
            bad++; $display("FAIL sh_result err=%0h rdata=%0h exp=0/0", a_err, a_rdata); end
        total++; if (a_bvalid !== 1'b0) begin bad++; $display("FAIL sh_bus_drop got=%0h exp=0", a_bvalid); end
    endtask

    task automatic test_misalign(input logic [1:0] size, input logic [31:0] addr);
        @(negedge clk);
        c_write = 1'b0; c_uns = 1'b0; c_size = size; c_addr = addr;
        a_bready = 1'b0; a_valid = 1'b1;
        @(negedge clk);
        a_valid = 1'b0;
        total++; if (a_bvalid !== 1'b0) begin bad++; $display("FAIL mis_no_bus sz=%0d got=%0h exp=0", size, a_bvalid); end
        total++; if (a_done !== 1'b1 || a_err !== 1'b1 || a_cause !== 2'd1) begin
            bad++; $display("FAIL mis_resp sz=%0d done=%0h err=%0h cause=%0h exp=1/1/1", size, a_done, a_err, a_cause); end
        @(negedge clk);
        total++; if (a_done !== 1'b0 || a_ready !== 1'b1 || a_bvalid !== 1'b0) begin
            bad++; $display("FAIL mis_after sz=%0d done=%0h ready=%0h bvalid=%0h exp=0/1/0", size, a_done, a_ready, a_bvalid); end
        total++; if (a_err !== 1'b1 || a_cause !== 2'd1) begin
            bad++; $display("FAIL mis_hold sz=%0d err=%0h cause=%0h exp=1/1", size, a_err, a_cause); end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        c_write = 1'b0; c_uns = 1'b0; c_size = 2'b10; c_addr = 32'h3001;
        a_bready = 1'b0; a_valid = 1'b1;
        @(negedge clk);
        total++; if (a_done !== 1'b1 || a_cause !== 2'd1) begin
            bad++; $display("FAIL b2b_first done=%0h cause=%0h exp=1/1", a_done, a_cause); end
        // valid stays high through RESP with a new aligned request
        c_addr = 32'h3004; rdata32 = 32'h1234_5678; a_bready = 1'b1;
        @(negedge clk);
        total++; if (a_ready !== 1'b1 || a_bvalid !== 1'b0) begin
            bad++; $display("FAIL b2b_resp_ignored ready=%0h bvalid=%0h exp=1/0", a_ready, a_bvalid); end
        @(negedge clk);
        a_valid = 1'b0;
        total++; if (a_bvalid !== 1'b1 || a_baddr !== 32'h3004 || a_bbe !== 4'hF) begin
            bad++; $display("FAIL b2b_bus valid=%0h addr=%0h be=%0h exp=1/3004/f", a_bvalid, a_baddr, a_bbe); end
        @(negedge clk);
        a_bready = 1'b0;
        total++; if (a_done !== 1'b1 || a_rdata !== 32'h1234_5678) begin
            bad++; $display("FAIL b2b_done done=%0h rdata=%0h exp=1/12345678", a_done, a_rdata); end
        total++; if (a_err !== 1'b0 || a_cause !== 2'd0) begin
            bad++; $display("FAIL b2b_err_clear err=%0h cause=%0h exp=0/0", a_err, a_cause); end
    endtask

    task automatic test_timeout();
        int n = 0;
        logic seen = 1'b0;
        @(negedge clk);
        c_write = 1'b0; c_uns = 1'b0; c_size = 2'b10; c_addr = 32'h0000_0010;
        t_bready = 1'b0; t_berr = 1'b0; t_valid = 1'b1;
        @(negedge clk);
        t_valid = 1'b0;
        for (int i = 0; i < 12 && !seen; i++) begin
            if (t_bvalid === 1'b1) n++;
            if (t_done === 1'b1) begin
                seen = 1'b1;
                total++; if (t_err !== 1'b1 || t_cause !== 2'd3 || t_rdata !== 32'h0) begin
                    bad++; $display("FAIL to_resp err=%0h cause=%0h rdata=%0h exp=1/3/0", t_err, t_cause, t_rdata); end
            end else begin
                @(negedge clk);
            end
        end
        total++; if (seen !== 1'b1) begin bad++; $display("FAIL to_done_seen got=%0h exp=1", seen); end
        total++; if (n != 4) begin bad++; $display("FAIL to_valid_cycles got=%0d exp=4", n); end
    endtask

    task automatic test_ready_at_limit();
        @(negedge clk);
        c_write = 1'b0; c_uns = 1'b0; c_size = 2'b10; c_addr = 32'h0000_0020;
        rdata32 = 32'hCAFE_F00D; t_bready = 1'b0; t_berr = 1'b0; t_valid = 1'b1;
        @(negedge clk);
        t_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            total++; if (t_bvalid !== 1'b1) begin bad++; $display("FAIL lim_valid cyc=%0d got=%0h exp=1", i, t_bvalid); end
            if (i == 3) t_bready = 1'b1;
            @(negedge clk);
        end
        t_bready = 1'b0;
        total++; if (t_done !== 1'b1 || t_err !== 1'b0 || t_cause !== 2'd0) begin
            bad++; $display("FAIL lim_ready_wins done=%0h err=%0h cause=%0h exp=1/0/0", t_done, t_err, t_cause); end
        total++; if (t_rdata !== 32'hCAFE_F00D) begin bad++; $display("FAIL lim_rdata got=%0h exp=cafef00d", t_rdata); end
    endtask

    task automatic test_bus_err();
        @(negedge clk);
        c_write = 1'b0; c_uns = 1'b0; c_size = 2'b01; c_addr = 32'h0000_0012;
        rdata32 = 32'h8000_0000; t_bready = 1'b1; t_berr = 1'b1; t_valid = 1'b1;
        @(negedge clk);
        t_valid = 1'b0;
        total++; if (t_bvalid !== 1'b1 || t_bbe !== 4'b1100) begin
            bad++; $display("FAIL be_bus valid=%0h be=%0b exp=1/1100", t_bvalid, t_bbe); end
        @(negedge clk);
        t_bready = 1'b0; t_berr = 1'b0;
        total++; if (t_done !== 1'b1 || t_err !== 1'b1 || t_cause !== 2'd2) begin
            bad++; $display("FAIL be_resp done=%0h err=%0h cause=%0h exp=1/1/2", t_done, t_err, t_cause); end
        total++; if (t_rdata !== 32'h0) begin bad++; $display("FAIL be_rdata got=%0h exp=0", t_rdata); end
    endtask

    task automatic test_double();
        @(negedge clk);
        c_write = 1'b0; c_uns = 1'b0; c_size = 2'b11; c_addr = 32'h4008;
        rdata64 = 64'h0123_4567_89AB_CDEF; d_bready = 1'b1; d_berr = 1'b0; d_valid = 1'b1;
        @(negedge clk);
        d_valid = 1'b0;
        total++; if (d_bvalid !== 1'b1 || d_baddr !== 32'h4008 || d_bbe !== 8'hFF) begin
            bad++; $display("FAIL dw_bus valid=%0h addr=%0h be=%0h exp=1/4008/ff", d_bvalid, d_baddr, d_bbe); end
        @(negedge clk);
        total++; if (d_done !== 1'b1 || d_rdata !== 64'h0123_4567_89AB_CDEF || d_err !== 1'b0) begin
            bad++; $display("FAIL dw_resp done=%0h rdata=%0h err=%0h exp=1/123456789abcdef/0", d_done, d_rdata, d_err); end
        // signed byte on lane 5 of the 64-bit beat
        @(negedge clk);
        c_size = 2'b00; c_addr = 32'h4005; rdata64 = 64'h0000_8100_0000_0000; d_valid = 1'b1;
        @(negedge clk);
        d_valid = 1'b0;
        total++; if (d_baddr !== 32'h4000 || d_bbe !== 8'b0010_0000) begin
            bad++; $display("FAIL d8_bus addr=%0h be=%0b exp=4000/00100000", d_baddr, d_bbe); end
        @(negedge clk);
        d_bready = 1'b0;
        total++; if (d_done !== 1'b1 || d_rdata !== 64'hFFFF_FFFF_FFFF_FF81) begin
            bad++; $display("FAIL d8_resp done=%0h rdata=%0h exp=1/ffffffffffffff81", d_done, d_rdata); end
    endtask

    task automatic test_reset_mid_bus();
        @(negedge clk);
        c_write = 1'b0; c_uns = 1'b0; c_size = 2'b10; c_addr = 32'h4000;
        d_bready = 1'b0; d_berr = 1'b0; d_valid = 1'b1;
        @(negedge clk);
        d_valid = 1'b0;
        total++; if (d_bvalid !== 1'b1) begin bad++; $display("FAIL rm_pre_valid got=%0h exp=1", d_bvalid); end
        #2 rst = 1'b0;
        #1;
        total++; if (d_bvalid !== 1'b0 || d_done !== 1'b0 || d_ready !== 1'b1) begin
            bad++; $display("FAIL rm_async bvalid=%0h done=%0h ready=%0h exp=0/0/1", d_bvalid, d_done, d_ready); end
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++; if (d_done !== 1'b0 || d_ready !== 1'b1 || d_bvalid !== 1'b0) begin
                bad++; $display("FAIL rm_after cyc=%0d done=%0h ready=%0h bvalid=%0h exp=0/1/0", i, d_done, d_ready, d_bvalid); end
        end
    endtask

    // ---------------- sequence ----------------
    initial begin
        rst = 1'b0;
        c_write = 1'b0; c_uns = 1'b0; c_size = 2'b00; c_addr = '0;
        c_wdata32 = '0; c_wdata64 = '0; rdata32 = '0; rdata64 = '0;
        a_valid = 1'b0; a_bready = 1'b0; a_berr = 1'b0;
        t_valid = 1'b0; t_bready = 1'b0; t_berr = 1'b0;
        d_valid = 1'b0; d_bready = 1'b0; d_berr = 1'b0;
        repeat (2) @(negedge clk);
        test_reset();
        test_load_byte(1'b0, 32'hFFFF_FF80);
        test_load_byte(1'b1, 32'h0000_0080);
        test_store_half();
        test_misalign(2'b10, 32'h3001);
        test_misalign(2'b11, 32'h3000);
        test_back_to_back();
        test_timeout();
        test_ready_at_limit();
        test_bus_err();
        test_double();
        test_reset_mid_bus();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
